tag_dir: RTL and testbench

TAG_DIR -- requirements
Module: tag_dir

---
 rtl/tag_dir.sv | 241 ++++++++++++++++++++++++
 tb/tb_tag_dir.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_dir.sv
`default_nettype none
// ============================================================================
// tag_dir : set-associative tag/valid/dirty directory with a dirty-line flush
//           walker. Optional macro TAG_DIR_PARITY_EN adds per-entry tag parity.
// Rev 1.0
// ============================================================================
module tag_dir #(
  parameter int ASSOC      = 8,
  parameter int ADDR_SIZE  = 32,
  parameter int BLOCK_SIZE = 6,
  parameter int INDEX_SIZE = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [ADDR_SIZE-1:0]     req_addr,
  input  logic [$clog2(ASSOC)-1:0] req_way,
  output logic                     rsp_valid,
  output logic                     rsp_hit,
  output logic [$clog2(ASSOC)-1:0] rsp_way,
  output logic                     rsp_dirty,
  output logic                     rsp_victim_valid,
  output logic [ADDR_SIZE-1:0]     rsp_victim_addr,
  input  logic                     flush_start,
  output logic                     flush_busy,
  output logic                     flush_done,
  output logic                     wb_valid,
  output logic [ADDR_SIZE-1:0]     wb_addr,
  input  logic                     wb_ready,
  output logic                     par_err
);
  localparam int TAG_SIZE = ADDR_SIZE - BLOCK_SIZE - INDEX_SIZE;
  localparam int SETS     = 2 ** INDEX_SIZE;
  localparam int WAYW     = $clog2(ASSOC);
  localparam int SCANW    = INDEX_SIZE + WAYW;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_FILL   = 2'b01;
  localparam logic [1:0] OP_DIRTY  = 2'b10;
  localparam logic [1:0] OP_INVAL  = 2'b11;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_WB = 2'd2, S_DONE = 2'd3} state_t;

  logic [SETS-1:0][ASSOC-1:0][TAG_SIZE-1:0] tag_q, tag_d;
  logic [SETS-1:0][ASSOC-1:0]               valid_q, valid_d, dirty_q, dirty_d;
  state_t                                   state_q, state_d;
  logic [SCANW-1:0]                         scan_q, scan_d;
  logic                                     rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d;
  logic [WAYW-1:0]                          rsp_way_q, rsp_way_d;
  logic                                     rsp_dirty_q, rsp_dirty_d, rsp_vv_q, rsp_vv_d;
  logic [ADDR_SIZE-1:0]                     rsp_vaddr_q, rsp_vaddr_d;

  logic [INDEX_SIZE-1:0] idx;
  logic [TAG_SIZE-1:0]   req_tag;
  logic [INDEX_SIZE-1:0] scan_set;
  logic [WAYW-1:0]       scan_way;
  logic                  scan_last, accept, hit;
  logic [ASSOC-1:0]      way_match;
  logic [WAYW-1:0]       hit_way;
  logic                  unused_offset;

`ifdef TAG_DIR_PARITY_EN
  logic [SETS-1:0][ASSOC-1:0] par_q, par_d;
  logic                       par_bad, par_err_q, par_err_d;
`endif

  assign idx           = req_addr[BLOCK_SIZE +: INDEX_SIZE];
  assign req_tag       = req_addr[ADDR_SIZE-1 -: TAG_SIZE];
  assign unused_offset = ^req_addr[BLOCK_SIZE-1:0];
  assign scan_set      = scan_q[SCANW-1 -: INDEX_SIZE];
  assign scan_way      = scan_q[WAYW-1:0];
  assign scan_last     = &scan_q;

  assign flush_busy = (state_q != S_IDLE);
  assign flush_done = (state_q == S_DONE);
  assign wb_valid   = (state_q == S_WB);
  assign wb_addr    = wb_valid ? {tag_q[scan_set][scan_way], scan_set, {BLOCK_SIZE{1'b0}}}
                               : '0;
  assign req_ready  = !flush_busy && !rst;
  assign accept     = req_valid && req_ready;

  assign rsp_valid        = rsp_valid_q;
  assign rsp_hit          = rsp_hit_q;
  assign rsp_way          = rsp_way_q;
  assign rsp_dirty        = rsp_dirty_q;
  assign rsp_victim_valid = rsp_vv_q;
  assign rsp_victim_addr  = rsp_vaddr_q;

  // A way whose stored parity disagrees with its tag can never hit.
  always_comb begin
    way_match = '0;
`ifdef TAG_DIR_PARITY_EN
    par_bad = 1'b0;
`endif
    for (int w = 0; w < ASSOC; w++) begin
      way_match[w] = valid_q[idx][w] && (tag_q[idx][w] == req_tag);
`ifdef TAG_DIR_PARITY_EN
      if (valid_q[idx][w] && ((^tag_q[idx][w]) != par_q[idx][w])) begin
        way_match[w] = 1'b0;
        par_bad      = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    hit     = |way_match;
    hit_way = '0;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (way_match[w]) hit_way = w[WAYW-1:0];
    end
  end

  always_comb begin
    tag_d       = tag_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    state_d     = state_q;
    scan_d      = scan_q;
    rsp_valid_d = 1'b0;
    rsp_hit_d   = 1'b0;
    rsp_way_d   = '0;
    rsp_dirty_d = 1'b0;
    rsp_vv_d    = 1'b0;
    rsp_vaddr_d = '0;
`ifdef TAG_DIR_PARITY_EN
    par_d     = par_q;
    par_err_d = 1'b0;
`endif
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_way_d   = req_way;
      case (req_op)
        OP_LOOKUP: begin
          if (hit) begin
            rsp_hit_d   = 1'b1;
            rsp_way_d   = hit_way;
            rsp_dirty_d = dirty_q[idx][hit_way];
          end else begin
            rsp_dirty_d = dirty_q[idx][req_way];
            rsp_vv_d    = valid_q[idx][req_way];
            rsp_vaddr_d = {tag_q[idx][req_way], idx, {BLOCK_SIZE{1'b0}}};
          end
`ifdef TAG_DIR_PARITY_EN
          par_err_d = par_bad;
`endif
        end
        OP_FILL: begin
          tag_d[idx][req_way]   = req_tag;
          valid_d[idx][req_way] = 1'b1;
          dirty_d[idx][req_way] = 1'b0;
          rsp_hit_d             = 1'b1;
`ifdef TAG_DIR_PARITY_EN
          par_d[idx][req_way] = ^req_tag;
`endif
        end
        OP_DIRTY: begin
          rsp_hit_d = valid_q[idx][req_way];
          if (valid_q[idx][req_way]) dirty_d[idx][req_way] = 1'b1;
        end
        default: begin
          rsp_dirty_d           = dirty_q[idx][req_way];
          valid_d[idx][req_way] = 1'b0;
          dirty_d[idx][req_way] = 1'b0;
        end
      endcase
    end

    // Requests are blocked while busy, so the walker owns the dirty bits here.
    case (state_q)
      S_IDLE: begin
        if (flush_start) begin
          state_d = S_SCAN;
          scan_d  = '0;
        end
      end
      S_SCAN: begin
        if (valid_q[scan_set][scan_way] && dirty_q[scan_set][scan_way]) state_d = S_WB;
        else if (scan_last) state_d = S_DONE;
        else scan_d = scan_q + 1'b1;
      end
      S_WB: begin
        if (wb_ready) begin
          dirty_d[scan_set][scan_way] = 1'b0;
          if (scan_last) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SCAN;
            scan_d  = scan_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      dirty_q     <= '0;
      state_q     <= S_IDLE;
      scan_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_way_q   <= '0;
      rsp_dirty_q <= 1'b0;
      rsp_vv_q    <= 1'b0;
      rsp_vaddr_q <= '0;
    end else begin
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      state_q     <= state_d;
      scan_q      <= scan_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_way_q   <= rsp_way_d;
      rsp_dirty_q <= rsp_dirty_d;
      rsp_vv_q    <= rsp_vv_d;
      rsp_vaddr_q <= rsp_vaddr_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

`ifdef TAG_DIR_PARITY_EN
  always_ff @(posedge clk) begin
    par_q <= par_d;
    if (rst) par_err_q <= 1'b0;
    else     par_err_q <= par_err_d;
  end
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tag_dir.sv
`default_nettype none
// tb_tag_dir: directed and randomized checks of tag_dir against a set/way array model.
module tb_tag_dir;
  localparam int ASSOC = 8, ADDR_SIZE = 32, BLOCK_SIZE = 6, INDEX_SIZE = 7;
  localparam int SETS  = 2 ** INDEX_SIZE;
  localparam int TAGSH = BLOCK_SIZE + INDEX_SIZE;

  logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0, flush_start = 1'b0, wb_ready = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_way = '0;
  logic        req_ready, rsp_valid, rsp_hit, rsp_dirty, rsp_victim_valid;
  logic [2:0]  rsp_way;
  logic [31:0] rsp_victim_addr, wb_addr;
  logic        flush_busy, flush_done, wb_valid, par_err;

  int n_cmp = 0, n_fail = 0;

  bit m_valid [SETS][ASSOC];
  bit m_dirty [SETS][ASSOC];
  int m_tag   [SETS][ASSOC];

  tag_dir #(.ASSOC(ASSOC), .ADDR_SIZE(ADDR_SIZE), .BLOCK_SIZE(BLOCK_SIZE), .INDEX_SIZE(INDEX_SIZE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_way(req_way), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
    .rsp_way(rsp_way), .rsp_dirty(rsp_dirty), .rsp_victim_valid(rsp_victim_valid),
    .rsp_victim_addr(rsp_victim_addr), .flush_start(flush_start), .flush_busy(flush_busy),
    .flush_done(flush_done), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_ready(wb_ready),
    .par_err(par_err)
  );

  always #5 clk = ~clk;

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> BLOCK_SIZE) % SETS);
  endfunction
  function automatic int tag_of(input logic [31:0] a);
    return int'(a >> TAGSH);
  endfunction
  function automatic logic [31:0] mk_addr(input int t, input int s);
    return 32'(longint'(t) * (longint'(1) << TAGSH) + longint'(s) * (longint'(1) << BLOCK_SIZE));
  endfunction

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", nm, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < ASSOC; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [2:0] way);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_way = way;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; flush_start = 1'b0; wb_ready = 1'b0;
    #1 chk("rst req_ready", req_ready, 0);
    @(posedge clk); #1;
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_hit", rsp_hit, 0);
    chk("rst rsp_victim_addr", rsp_victim_addr, 0);
    chk("rst wb_valid", wb_valid, 0);
    chk("rst wb_addr", wb_addr, 0);
    chk("rst flush_busy", flush_busy, 0);
    chk("rst flush_done", flush_done, 0);
    chk("rst par_err", par_err, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    #1 chk("post-rst req_ready", req_ready, 1);
  endtask

  task automatic do_lookup(input string nm, input logic [31:0] addr, input logic [2:0] way);
    int s = set_of(addr);
    int t = tag_of(addr);
    int hw = -1;
    for (int w = 0; w < ASSOC; w++)
      if (hw < 0 && m_valid[s][w] && m_tag[s][w] == t) hw = w;
    issue(2'b00, addr, way);
    chk({nm, " rsp_valid"}, rsp_valid, 1);
    chk({nm, " rsp_hit"}, rsp_hit, (hw >= 0));
    chk({nm, " par_err"}, par_err, 0);
    if (hw >= 0) begin
      chk({nm, " hit way"}, rsp_way, hw);
      chk({nm, " hit dirty"}, rsp_dirty, m_dirty[s][hw]);
      chk({nm, " hit vv"}, rsp_victim_valid, 0);
      chk({nm, " hit vaddr"}, rsp_victim_addr, 0);
    end else begin
      chk({nm, " miss way"}, rsp_way, way);
      chk({nm, " miss dirty"}, rsp_dirty, m_dirty[s][way]);
      chk({nm, " miss vv"}, rsp_victim_valid, m_valid[s][way]);
      if (m_valid[s][way]) chk({nm, " miss vaddr"}, rsp_victim_addr, mk_addr(m_tag[s][way], s));
    end
  endtask

  task automatic do_fill(input string nm, input logic [31:0] addr, input logic [2:0] way);
    int s = set_of(addr);
    issue(2'b01, addr, way);
    chk({nm, " fill rsp_valid"}, rsp_valid, 1);
    chk({nm, " fill rsp_hit"}, rsp_hit, 1);
    chk({nm, " fill rsp_way"}, rsp_way, way);
    m_tag[s][way] = tag_of(addr); m_valid[s][way] = 1'b1; m_dirty[s][way] = 1'b0;
  endtask

  task automatic do_setd(input string nm, input logic [31:0] addr, input logic [2:0] way);
    int s = set_of(addr);
    issue(2'b10, addr, way);
    chk({nm, " setd rsp_valid"}, rsp_valid, 1);
    chk({nm, " setd rsp_hit"}, rsp_hit, m_valid[s][way]);
    if (m_valid[s][way]) m_dirty[s][way] = 1'b1;
  endtask

  task automatic do_inval(input string nm, input logic [31:0] addr, input logic [2:0] way);
    int s = set_of(addr);
    issue(2'b11, addr, way);
    chk({nm, " inval rsp_valid"}, rsp_valid, 1);
    chk({nm, " inval rsp_dirty"}, rsp_dirty, m_dirty[s][way]);
    m_valid[s][way] = 1'b0; m_dirty[s][way] = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b, c, d, p;
    logic [31:0] wbq[$];
    int nwb, ndone, stall, bad_ready, bad_addr;
    bit fin;

    repeat (2) @(posedge clk);
    do_reset();

    do_lookup("cold", 32'h0000_1040, 3'd0);
    @(posedge clk); #1 chk("rsp_valid single pulse", rsp_valid, 0);

    do_fill("f1", 32'h1234_5680, 3'd3);
    do_lookup("hit clean", 32'h1234_5680, 3'd0);
    do_setd("d1", 32'h1234_5680, 3'd3);
    do_lookup("hit dirty", 32'h1234_5680, 3'd1);
    do_lookup("dirty victim", 32'hABCD_5680, 3'd3);
    chk("dirty victim addr", rsp_victim_addr, 32'h1234_5680);
    chk("dirty victim flag", rsp_victim_valid, 1);

    p = mk_addr(32'h3A, 9);
    do_fill("dup6", p, 3'd6);
    do_fill("dup2", p, 3'd2);
    do_lookup("lowest way wins", p, 3'd7);
    chk("lowest way", rsp_way, 3'd2);
    do_setd("setd invalid", mk_addr(5, 11), 3'd4);
    do_lookup("after setd invalid", mk_addr(5, 11), 3'd4);
    do_inval("inval dirty", 32'h1234_5680, 3'd3);
    do_lookup("after inval", 32'h1234_5680, 3'd3);

    for (int i = 0; i < 300; i++) begin
      int t  = 32'h100 + int'($urandom_range(3, 0));
      int s  = int'($urandom_range(3, 0)) * 37 % SETS;
      logic [31:0] ra = mk_addr(t, s) | 32'($urandom_range(63, 0));
      logic [2:0]  rw = 3'($urandom_range(7, 0));
      case ($urandom_range(3, 0))
        0, 1: do_lookup("rnd lookup", ra, rw);
        2: begin
          if ($urandom_range(1, 0) == 0) do_fill("rnd", ra, rw);
          else do_setd("rnd", ra, rw);
        end
        default: do_inval("rnd", ra, rw);
      endcase
    end

    // Flush with two dirty lines and one clean one.
    do_reset();
    a = mk_addr(32'h55, 2); b = mk_addr(32'h66, 1); c = mk_addr(32'h77, 1);
    do_fill("fa", a, 3'd5); do_fill("fb", b, 3'd0); do_fill("fc", c, 3'd4);
    do_setd("fa", a, 3'd5); do_setd("fb", b, 3'd0);
    wbq = {};
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < ASSOC; w++)
        if (m_valid[s][w] && m_dirty[s][w]) wbq.push_back(mk_addr(m_tag[s][w], s));

    @(negedge clk);
    flush_start = 1'b1; req_valid = 1'b1; req_op = 2'b00; req_addr = c; req_way = 3'd0;
    @(posedge clk); #1;
    flush_start = 1'b0; req_valid = 1'b0;
    chk("flush+req rsp_valid", rsp_valid, 1);
    chk("flush+req rsp_hit", rsp_hit, 1);
    chk("flush busy after start", flush_busy, 1);

    nwb = 0; ndone = 0; stall = 0; bad_ready = 0; bad_addr = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      @(negedge clk);
      if (flush_busy && req_ready) bad_ready++;
      if (flush_done) ndone++;
      if (wb_valid) begin
        if (nwb >= wbq.size() || wb_addr !== wbq[nwb]) bad_addr++;
        if (stall < 5) begin wb_ready = 1'b0; stall++; end
        else begin wb_ready = 1'b1; stall = 0; nwb++; end
      end else begin
        wb_ready = 1'b0;
      end
      if (!flush_busy) fin = 1'b1;
    end
    wb_ready = 1'b0;
    chk("flush finished", fin, 1);
    chk("flush wb count", nwb, wbq.size());
    chk("flush wb addr order/stable", bad_addr, 0);
    chk("flush done pulses", ndone, 1);
    chk("req_ready low while busy", bad_ready, 0);
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < ASSOC; w++) m_dirty[s][w] = 1'b0;
    do_lookup("post flush a", a, 3'd0);
    do_lookup("post flush b", b, 3'd0);

    // Reset while a writeback is pending.
    do_reset();
    d = mk_addr(32'h99, 3);
    do_fill("fd", d, 3'd1); do_setd("fd", d, 3'd1);
    @(negedge clk); flush_start = 1'b1;
    @(negedge clk); flush_start = 1'b0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      @(negedge clk);
      if (wb_valid) fin = 1'b1;
    end
    chk("abort wb reached", wb_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort wb_valid", wb_valid, 0);
    chk("abort flush_busy", flush_busy, 0);
    chk("abort flush_done", flush_done, 0);
    @(negedge clk); rst = 1'b0; clear_model();
    ndone = 0;
    repeat (4) begin @(negedge clk); if (flush_done) ndone++; end
    chk("abort no done pulse", ndone, 0);
    do_lookup("abort lookup misses", d, 3'd1);

`ifdef TAG_DIR_PARITY_EN
    p = mk_addr(32'h123, 5);
    do_fill("par", p, 3'd2);
    force dut.tag_q[5][2][0] = 1'b0;
    issue(2'b00, p, 3'd2);
    chk("parity rsp_hit", rsp_hit, 0);
    chk("parity par_err", par_err, 1);
    release dut.tag_q[5][2][0];
    do_fill("par restore", p, 3'd2);
    do_lookup("parity restored", p, 3'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
